sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param.sv | 107 ++++++++++
 tb/tb_sync_fifo_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill level, almost-full/empty thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through reads; otherwise reads are registered (latency 1).
module sync_fifo_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   wr,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   rd,
    output logic [WIDTH-1:0]       data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;

    assign full         = (level_q == LW'(DEPTH));
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= LW'(AF_LEVEL));
    assign almost_empty = (level_q <= LW'(AE_LEVEL));
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A pop frees a slot in the same cycle, so a write into a full FIFO succeeds alongside a read.
    always_comb begin
        rd_acc      = en & rd & ~empty;
        wr_acc      = en & wr & (~full | rd_acc);
        wr_ptr_d    = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d     = level_q;
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        overflow_d  = overflow_q  | (en & wr & ~wr_acc);
        underflow_d = underflow_q | (en & rd & ~rd_acc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; reset only discards contents by zeroing the pointers.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is shown directly; forced to zero while empty so reset leaves data_out at 0.
    assign data_out = empty ? '0 : mem[rd_ptr_q];
`else
    logic [WIDTH-1:0] data_out_q, data_out_d;

    always_comb begin
        data_out_d = data_out_q;
        if (rd_acc) begin
            data_out_d = mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (WIDTH=32, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
module tb_sync_fifo_param;

    typedef struct {
        logic        en;
        logic        wr;
        logic        rd;
        logic [31:0] din;
        int          exp_level;
        logic [31:0] exp_dout;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        full, empty, almost_full, almost_empty;
    logic [3:0]  level;
    logic        overflow, underflow;

    int assertCount = 0;
    int failCount = 0;
    vec_t vecs[16];

    sync_fifo_param #(.WIDTH(32), .DEPTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .wr(wr),
        .data_in(data_in),
        .rd(rd),
        .data_out(data_out),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .level(level),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(logic e, logic w, logic r, logic [31:0] d,
                                   int lvl, logic [31:0] dout, logic ovf, logic unf);
        vec_t v;
        v.en = e; v.wr = w; v.rd = r; v.din = d;
        v.exp_level = lvl; v.exp_dout = dout; v.exp_ovf = ovf; v.exp_unf = unf;
        return v;
    endfunction

    task automatic compareValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of requests, let the edge happen, and settle 1 time unit after it.
    task automatic applyStimulus(input logic e, input logic w, input logic r, input logic [31:0] d);
        en = e; wr = w; rd = r; data_in = d;
        @(posedge clk);
        #1;
        en = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        reset = 1'b0;
    endtask

    // Flags are checked against the fixed thresholds of this configuration.
    task automatic checkOutput(input string name, input int expLevel, input logic [31:0] expDout,
                               input logic expOvf, input logic expUnf);
        compareValue({name, ".level"}, 32'(level), 32'(expLevel));
        compareValue({name, ".empty"}, 32'(empty), 32'(expLevel == 0));
        compareValue({name, ".full"}, 32'(full), 32'(expLevel == 8));
        compareValue({name, ".almost_full"}, 32'(almost_full), 32'(expLevel >= 6));
        compareValue({name, ".almost_empty"}, 32'(almost_empty), 32'(expLevel <= 2));
        compareValue({name, ".overflow"}, 32'(overflow), 32'(expOvf));
        compareValue({name, ".underflow"}, 32'(underflow), 32'(expUnf));
`ifndef FIFO_FWFT_EN
        compareValue({name, ".data_out"}, data_out, expDout);
`endif
    endtask

    initial begin
        // Fill 0x10..0x17, then drain in order.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = mkVec(1'b1, 1'b1, 1'b0, 32'h10 + 32'(i), i + 1, 32'h0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            vecs[8 + i] = mkVec(1'b1, 1'b0, 1'b1, 32'h0, 7 - i, 32'h10 + 32'(i), 1'b0, 1'b0);
        end

        @(posedge clk);
        #1;
        doReset();
        checkOutput("reset", 0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].en, vecs[i].wr, vecs[i].rd, vecs[i].din);
            checkOutput($sformatf("fill_drain[%0d]", i), vecs[i].exp_level,
                        vecs[i].exp_dout, vecs[i].exp_ovf, vecs[i].exp_unf);
        end

        // Wrap-around: single write then single read, 20 times.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h100 + 32'(i));
            checkOutput($sformatf("wrap_wr[%0d]", i), 1,
                        (i == 0) ? 32'h17 : 32'h100 + 32'(i - 1), 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b1, '0);
            checkOutput($sformatf("wrap_rd[%0d]", i), 0, 32'h100 + 32'(i), 1'b0, 1'b0);
        end

        // Simultaneous read and write while full.
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'(i));
        checkOutput("full_before", 8, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hAA);
        checkOutput("full_rdwr", 8, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, '0);
            checkOutput($sformatf("full_drain[%0d]", i), 8 - i, 32'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, '0);
        checkOutput("full_drain_aa", 0, 32'hAA, 1'b0, 1'b0);

        // Error flags: nine writes, ten reads, then reset clears them.
        doReset();
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h20 + 32'(i));
        checkOutput("ovf_set", 8, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, '0);
            checkOutput($sformatf("ovf_drain[%0d]", i), 7 - i, 32'h20 + 32'(i), 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, '0);
        checkOutput("unf_rd9", 0, 32'h27, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, '0);
        checkOutput("unf_rd10", 0, 32'h27, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("flags_sticky", 0, 32'h27, 1'b1, 1'b1);
        doReset();
        checkOutput("flags_cleared", 0, 32'h0, 1'b0, 1'b0);

        // en=0 ignores requests, including would-be errors.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h30 + 32'(i));
        checkOutput("en_off_wr", 0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkOutput("en_off_rd", 0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h40 + 32'(i));
        checkOutput("en_on_wr", 3, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, '0);
        checkOutput("en_on_rd", 2, 32'h40, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h99);
        checkOutput("en_off_hold", 2, 32'h40, 1'b0, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, '0);
        reset = 1'b0;
        checkOutput("reset_mid_traffic", 0, 32'h0, 1'b0, 1'b0);

        // Empty with read and write together: write lands, read rejected.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h77);
        checkOutput("empty_rdwr", 1, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, '0);
        checkOutput("empty_rdwr_pop", 0, 32'h77, 1'b0, 1'b1);

`ifdef FIFO_FWFT_EN
        doReset();
        compareValue("fwft_reset.data_out", data_out, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h55);
        compareValue("fwft_wr.data_out", data_out, 32'h55);
        checkOutput("fwft_wr", 1, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, '0);
        checkOutput("fwft_rd", 0, 32'h0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
